// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types, constants and helpers for the multi-slot alarm clock.
//   alarm_state_t : alarm sequencer states
//   bcd_digit_t   : one BCD digit
//   hhmm_t        : packed BCD hours:minutes {hour1, hour0, min1, min0}
//   hhmm_valid    : legality check of a BCD hh:mm value
//   hhmm_inc      : advance a legal hh:mm by one minute, wrapping 23:59 -> 00:00
//   hhmm_to_min   : minute-of-day (0..1439) of a legal hh:mm
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } alarm_state_t;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    logic [1:0] hour1;
    bcd_digit_t hour0;
    bcd_digit_t min1;
    bcd_digit_t min0;
  } hhmm_t;

  localparam int         MIN_W           = 11;
  localparam logic [10:0] MINUTES_PER_DAY = 11'd1440;
  localparam logic [1:0] HOUR1_MAX       = 2'd2;
  localparam bcd_digit_t HOUR0_MAX_LATE  = 4'd3;  // last legal hour0 when hour1 == 2
  localparam bcd_digit_t MIN1_MAX        = 4'd5;
  localparam bcd_digit_t DIGIT_MAX       = 4'd9;

  function automatic logic hhmm_valid(input hhmm_t t);
    return (t.hour0 <= DIGIT_MAX) && (t.min0 <= DIGIT_MAX) && (t.min1 <= MIN1_MAX) &&
           ((t.hour1 < HOUR1_MAX) ||
            ((t.hour1 == HOUR1_MAX) && (t.hour0 <= HOUR0_MAX_LATE)));
  endfunction

  // Pure digit-wise carry chain so every digit stays a legal BCD value.
  function automatic hhmm_t hhmm_inc(input hhmm_t t);
    hhmm_t n;
    n = t;
    if (t.min0 != DIGIT_MAX) begin
      n.min0 = t.min0 + 4'd1;
    end else begin
      n.min0 = 4'd0;
      if (t.min1 != MIN1_MAX) begin
        n.min1 = t.min1 + 4'd1;
      end else begin
        n.min1 = 4'd0;
        if ((t.hour1 == HOUR1_MAX) && (t.hour0 == HOUR0_MAX_LATE)) begin
          n.hour1 = 2'd0;
          n.hour0 = 4'd0;
        end else if (t.hour0 == DIGIT_MAX) begin
          n.hour1 = t.hour1 + 2'd1;
          n.hour0 = 4'd0;
        end else begin
          n.hour0 = t.hour0 + 4'd1;
        end
      end
    end
    return n;
  endfunction

  // Constant multiplies only; the reverse (binary -> BCD) direction is never needed.
  function automatic logic [10:0] hhmm_to_min(input hhmm_t t);
    return (11'(t.hour1) * 11'd600) + (11'(t.hour0) * 11'd60) +
           (11'(t.min1) * 11'd10) + 11'(t.min0);
  endfunction

endpackage

// File: rtl/multi_alarm_clock_tick_gen.sv
// tick_gen: one-second prescaler.
//   clock : system clock
//   reset : synchronous active-low reset
//   clear : restart the count at 0 (time load)
//   tick  : registered, high for exactly the cycle the count sits at CLK_HZ-1
module tick_gen #(
  parameter int CLK_HZ = 100000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int             CW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0]  LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic          tick_r;

  // Next count with wrap at CLK_HZ-1.
  always_comb begin
    cnt_next_s = cnt_r;
    if (cnt_r == LAST) begin
      cnt_next_s = '0;
    end else begin
      cnt_next_s = cnt_r + 1'b1;
    end
  end

  // Count register; tick is registered alongside so it marks the terminal count.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (clear) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_next_s;
      tick_r <= (cnt_next_s == LAST);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock: BCD time-of-day clock with N_ALARMS alarm slots,
// snooze and ring timeout.
//   clock, reset           : system clock, synchronous active-low reset
//   hour_in1..minute_in0   : BCD load value for load_time / load_alarm
//   load_time, load_alarm  : load strobes (both may be high together)
//   alarm_sel              : slot written by load_alarm
//   alarm_en               : per-slot arm enable
//   STOP_alarm, snooze     : user controls, sampled each cycle
//   Alarm                  : high while ringing
//   alarm_src              : sticky mask of slots that fired
//   hour_out1..minute_out0 : BCD time, seconds: binary 0..59
//   tick_1s                : one-cycle pulse when the time advanced
//   load_err               : one-cycle pulse after a rejected load
module multi_alarm_clock
  import alarm_pkg::*;
#(
  parameter int CLK_HZ         = 100000000,
  parameter int N_ALARMS       = 4,
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60
) (
  input  logic                                            clock,
  input  logic                                            reset,
  input  logic [1:0]                                      hour_in1,
  input  logic [3:0]                                      hour_in0,
  input  logic [3:0]                                      minute_in1,
  input  logic [3:0]                                      minute_in0,
  input  logic                                            load_time,
  input  logic                                            load_alarm,
  input  logic [((N_ALARMS > 1) ? $clog2(N_ALARMS) : 1)-1:0] alarm_sel,
  input  logic [N_ALARMS-1:0]                             alarm_en,
  input  logic                                            STOP_alarm,
  input  logic                                            snooze,
  output logic                                            Alarm,
  output logic [N_ALARMS-1:0]                             alarm_src,
  output logic [1:0]                                      hour_out1,
  output logic [3:0]                                      hour_out0,
  output logic [3:0]                                      minute_out1,
  output logic [3:0]                                      minute_out0,
  output logic [5:0]                                      seconds,
  output logic                                            tick_1s,
  output logic                                            load_err
);

  localparam int               SEL_W     = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;
  localparam logic [SEL_W:0]   N_SLOTS   = (SEL_W + 1)'(N_ALARMS);
  localparam logic [7:0]       RING_LAST = 8'(RING_TIMEOUT_S - 1);
  localparam logic [MIN_W-1:0] SNZ_MIN   = MIN_W'(SNOOZE_MIN);

  hhmm_t            hhmm_r, hhmm_next_s, in_hhmm_s;
  hhmm_t            slot_r [N_ALARMS];
  logic [5:0]       sec_r, sec_next_s;
  logic             tick_s, in_ok_s, sel_ok_s, time_load_ok_s, alarm_load_ok_s, load_bad_s;
  logic             adv_s, wrap_s, wake_s, alarm_s;
  logic [N_ALARMS-1:0] match_s, src_r;
  logic [MIN_W-1:0] min_sum_s, snz_tgt_s, snz_tgt_r;
  logic [7:0]       ring_cnt_r;
  logic             alarm_r, tick_1s_r, load_err_r;
  alarm_state_t     state_r, state_next_s;

  assign in_hhmm_s       = {hour_in1, hour_in0, minute_in1, minute_in0};
  assign in_ok_s         = hhmm_valid(in_hhmm_s);
  assign sel_ok_s        = ({1'b0, alarm_sel} < N_SLOTS);
  assign time_load_ok_s  = load_time & in_ok_s;
  assign alarm_load_ok_s = load_alarm & in_ok_s & sel_ok_s;
  assign load_bad_s      = (load_time & ~in_ok_s) | (load_alarm & ~(in_ok_s & sel_ok_s));

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .clock (clock),
    .reset (reset),
    .clear (time_load_ok_s),
    .tick  (tick_s)
  );

  // A time load wins over a same-cycle tick, so only un-overridden ticks advance time.
  assign adv_s  = tick_s & ~time_load_ok_s;
  assign wrap_s = adv_s & (sec_r == 6'd59);

  // Next time of day: load, advance on tick, or hold.
  always_comb begin
    hhmm_next_s = hhmm_r;
    sec_next_s  = sec_r;
    if (time_load_ok_s) begin
      hhmm_next_s = in_hhmm_s;
      sec_next_s  = 6'd0;
    end else if (wrap_s) begin
      hhmm_next_s = hhmm_inc(hhmm_r);
      sec_next_s  = 6'd0;
    end else if (adv_s) begin
      sec_next_s = sec_r + 6'd1;
    end else begin
      sec_next_s = sec_r;
    end
  end

  // Slot matches happen only on a tick that lands on seconds==0.
  always_comb begin
    match_s = '0;
    for (int i = 0; i < N_ALARMS; i++) begin
      if (wrap_s && alarm_en[i] && (slot_r[i] == hhmm_next_s)) begin
        match_s[i] = 1'b1;
      end else begin
        match_s[i] = 1'b0;
      end
    end
  end

  // Snooze target as minute-of-day, wrapped past midnight by one subtraction.
  always_comb begin
    min_sum_s = hhmm_to_min(hhmm_r) + SNZ_MIN;
    if (min_sum_s >= MINUTES_PER_DAY) begin
      snz_tgt_s = min_sum_s - MINUTES_PER_DAY;
    end else begin
      snz_tgt_s = min_sum_s;
    end
  end

  assign wake_s = wrap_s & (hhmm_to_min(hhmm_next_s) == snz_tgt_r);

  // Alarm state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Alarm next-state logic; STOP_alarm outranks every other event.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (STOP_alarm)    state_next_s = IDLE;
        else if (|match_s) state_next_s = RINGING;
        else               state_next_s = IDLE;
      end
      RINGING: begin
        if (STOP_alarm)                           state_next_s = IDLE;
        else if (snooze)                          state_next_s = SNOOZED;
        else if (adv_s && (ring_cnt_r == RING_LAST)) state_next_s = IDLE;
        else                                      state_next_s = RINGING;
      end
      SNOOZED: begin
        if (STOP_alarm)              state_next_s = IDLE;
        else if ((|match_s) || wake_s) state_next_s = RINGING;
        else                         state_next_s = SNOOZED;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Alarm output decode, taken from the next state so the registered output lines up with it.
  always_comb begin
    alarm_s = 1'b0;
    case (state_next_s)
      RINGING: alarm_s = 1'b1;
      default: alarm_s = 1'b0;
    endcase
  end

  // Time of day, alarm slots and one-cycle status pulses.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hhmm_r     <= '0;
      sec_r      <= 6'd0;
      tick_1s_r  <= 1'b0;
      load_err_r <= 1'b0;
      for (int i = 0; i < N_ALARMS; i++) slot_r[i] <= '0;
    end else begin
      hhmm_r     <= hhmm_next_s;
      sec_r      <= sec_next_s;
      tick_1s_r  <= adv_s;
      load_err_r <= load_bad_s;
      for (int i = 0; i < N_ALARMS; i++) begin
        if (alarm_load_ok_s && (alarm_sel == SEL_W'(i))) slot_r[i] <= in_hhmm_s;
        else                                             slot_r[i] <= slot_r[i];
      end
    end
  end

  // Ring-second counter (restarts on every entry to RINGING), snooze target, source mask, Alarm.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ring_cnt_r <= 8'd0;
      snz_tgt_r  <= '0;
      src_r      <= '0;
      alarm_r    <= 1'b0;
    end else begin
      if ((state_r != RINGING) || (state_next_s != RINGING)) ring_cnt_r <= 8'd0;
      else if (adv_s)                                        ring_cnt_r <= ring_cnt_r + 8'd1;
      else                                                   ring_cnt_r <= ring_cnt_r;
      if ((state_r == RINGING) && (state_next_s == SNOOZED)) snz_tgt_r <= snz_tgt_s;
      else                                                   snz_tgt_r <= snz_tgt_r;
      if (STOP_alarm) src_r <= '0;
      else            src_r <= src_r | match_s;
      alarm_r <= alarm_s;
    end
  end

  assign {hour_out1, hour_out0, minute_out1, minute_out0} = hhmm_r;
  assign seconds   = sec_r;
  assign Alarm     = alarm_r;
  assign alarm_src = src_r;
  assign tick_1s   = tick_1s_r;
  assign load_err  = load_err_r;

endmodule

// File: doc/multi_alarm_clock.md
MULTI_ALARM_CLOCK -- requirements
Module: multi_alarm_clock

Interface
REQ-001 SHALL have parameter CLK_HZ, 100000000, clock cycles per real-time second (>=2).
REQ-002 SHALL have parameter N_ALARMS, 4, number of independent alarm slots (1..8).
REQ-003 SHALL have parameter SNOOZE_MIN, 5, snooze delay in minutes (1..59).
REQ-004 SHALL have parameter RING_TIMEOUT_S, 60, seconds of ringing before auto-stop (1..255).
REQ-005 SHALL have port clock  in  1  single system clock, all logic posedge.
REQ-006 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-007 SHALL have ports hour_in1 in 2, hour_in0 in 4, minute_in1 in 4, minute_in0 in 4  BCD load value.
REQ-008 SHALL have port load_time  in  1  load the BCD input into the time of day.
REQ-009 SHALL have port load_alarm  in  1  load the BCD input into slot alarm_sel.
REQ-010 SHALL have port alarm_sel  in  max(1,clog2(N_ALARMS))  target slot for load_alarm.
REQ-011 SHALL have port alarm_en  in  N_ALARMS  per-slot arm enable.
REQ-012 SHALL have ports STOP_alarm in 1 and snooze in 1  level-sampled user controls.
REQ-013 SHALL have port Alarm  out  1  high while in RINGING.
REQ-014 SHALL have port alarm_src  out  N_ALARMS  sticky one-hot-or mask of slots that fired.
REQ-015 SHALL have ports hour_out1 out 2, hour_out0 out 4, minute_out1 out 4, minute_out0 out 4  registered BCD time.
REQ-016 SHALL have port seconds  out  6  binary seconds 0..59.
REQ-017 SHALL have ports tick_1s out 1 (one-cycle pulse per second) and load_err out 1 (one-cycle pulse on a rejected load).

Function
REQ-018 Prescaler SHALL count 0..CLK_HZ-1 and assert tick_1s for exactly one cycle when it reaches CLK_HZ-1, then wrap to 0.
REQ-019 On tick, seconds SHALL increment; 59 wraps to 0 and carries into minutes; minute 59 carries into hours; 23:59:59 wraps to 00:00:00.
REQ-020 BCD digits SHALL always hold legal values (hour 00..23, minute 00..59); no binary-to-BCD division logic.
REQ-021 load_time with valid input SHALL, next cycle, set hh:mm to input, seconds to 0, prescaler to 0; it overrides a tick in the same cycle.
REQ-022 A load with hour>23, minute_in1>5, or any digit>9 SHALL be ignored and pulse load_err one cycle later.
REQ-023 load_alarm with valid input SHALL write slot alarm_sel; load_time and load_alarm together SHALL both apply; alarm_sel>=N_ALARMS SHALL be rejected via load_err.
REQ-024 A slot i SHALL match when a tick advances time to seconds==0 and the new hh:mm equals slot i and alarm_en[i]=1; load_time never produces a match.
REQ-025 Alarm FSM states: IDLE, RINGING, SNOOZED.
REQ-026 IDLE -> RINGING on any match; matching bits SHALL be ORed into alarm_src.
REQ-027 RINGING: further matches SHALL OR into alarm_src; snooze=1 -> SNOOZED with target = current minute-of-day + SNOOZE_MIN modulo 1440; ring-second counter reaching RING_TIMEOUT_S -> IDLE.
REQ-028 SNOOZED: tick reaching target with seconds==0 -> RINGING with ring counter cleared; a slot match -> RINGING immediately.
REQ-029 STOP_alarm=1 in RINGING or SNOOZED SHALL go to IDLE next cycle and clear alarm_src; STOP_alarm SHALL take priority over snooze and over a same-cycle match.
REQ-030 Deasserting alarm_en[i] SHALL not stop an alarm already ringing.
REQ-031 Alarm SHALL be registered, asserted the cycle after the matching tick.

Reset
REQ-032 reset=0 at a clock edge SHALL set time 00:00:00, prescaler 0, all slots 00:00, FSM IDLE, Alarm/alarm_src/tick_1s/load_err 0; reset mid-ring or mid-snooze SHALL abort to IDLE.

Structure
REQ-033 Package alarm_pkg SHALL hold the FSM state typedef, BCD digit typedef, MINUTES_PER_DAY=1440 and digit-limit constants.
REQ-034 Prescaler SHALL be sub-module tick_gen (parameter CLK_HZ; ports clock, reset, clear, tick).

Verification (CLK_HZ=4, N_ALARMS=2, SNOOZE_MIN=1, RING_TIMEOUT_S=5)
REQ-035 load_time 23:59, run 60 ticks -> 00:00:00, tick_1s every 4 cycles.
REQ-036 Slot0=07:30, en=01, load_time 07:29, 60 ticks -> Alarm=1, alarm_src=01; STOP_alarm -> Alarm=0, src=00.
REQ-037 Ring at 07:30, snooze at 07:30:02 -> Alarm=0; at 07:31:00 -> Alarm=1 again.
REQ-038 Slots 0 and 1 both 12:00, en=11 -> alarm_src=11; no STOP for 5 ticks -> IDLE, Alarm=0.
REQ-039 load_time hour 24 or minute_in1=6 -> load_err pulse, time unchanged; STOP_alarm and snooze together -> IDLE.
REQ-040 Assert reset=0 while RINGING -> Alarm=0, time 00:00:00, slots cleared.
